// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel clock-enable prescaler plus horizontal/vertical
// counters with registered sync, data-enable and line/frame start pulses.
module vga_timing_ctrl #(
    parameter int CE_DIV   = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int CW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    logic [CW-1:0] ce_cnt;
    logic [9:0]    x_nxt;
    logic [9:0]    y_nxt;
    logic          hs_reg_nxt;
    logic          vs_reg_nxt;

    assign pix_ce = en && (ce_cnt == CW'(CE_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_cnt <= '0;
        end else if (en) begin
            ce_cnt <= (ce_cnt == CW'(CE_DIV - 1)) ? '0 : ce_cnt + CW'(1);
        end
    end

    // Decode regions from the next count so sync/de land on the same edge as x/y.
    always_comb begin
        x_nxt = x + 10'd1;
        y_nxt = y;
        if (x == 10'(H_TOTAL - 1)) begin
            x_nxt = '0;
            y_nxt = (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
        end
        hs_reg_nxt = (x_nxt >= 10'(HS_BEG)) && (x_nxt < 10'(HS_END));
        vs_reg_nxt = (y_nxt >= 10'(VS_BEG)) && (y_nxt < 10'(VS_END));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= 10'(H_TOTAL - 1);
            y           <= 10'(V_TOTAL - 1);
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                x           <= x_nxt;
                y           <= y_nxt;
                hsync       <= hs_reg_nxt ? SYNC_POL : ~SYNC_POL;
                vsync       <= vs_reg_nxt ? SYNC_POL : ~SYNC_POL;
                de          <= (x_nxt < 10'(H_ACTIVE)) && (y_nxt < 10'(V_ACTIVE));
                line_start  <= (x_nxt == '0);
                frame_start <= (x_nxt == '0) && (y_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default 640x480 build (CE_DIV=2) and a CE_DIV=1 build with a
// short 8-line frame so whole-frame behaviour fits in a short run.
module tb_vga_timing_ctrl;

    logic       clk = 1'b0;
    logic       rst0, en0, pce0, hs0, vs0, de0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       rst1, en1, pce1, hs1, vs1, de1, ls1, fs1;
    logic [9:0] x1, y1;

    int npass = 0;
    int ntot  = 0;

    always #10 clk = ~clk;

    vga_timing_ctrl u0 (
        .clk(clk), .rst(rst0), .en(en0), .pix_ce(pce0), .hsync(hs0), .vsync(vs0),
        .de(de0), .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_ctrl #(.CE_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .pix_ce(pce1), .hsync(hs1), .vsync(vs1),
        .de(de1), .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_rst0(input string pfx);
        chk({pfx, "_x"}, 32'(x0), 799);
        chk({pfx, "_y"}, 32'(y0), 524);
        chk({pfx, "_hs"}, 32'(hs0), 1);
        chk({pfx, "_vs"}, 32'(vs0), 1);
        chk({pfx, "_de"}, 32'(de0), 0);
        chk({pfx, "_pce"}, 32'(pce0), 0);
        chk({pfx, "_ls"}, 32'(ls0), 0);
        chk({pfx, "_fs"}, 32'(fs0), 0);
    endtask

    task automatic chk_start0(input string pfx);
        @(negedge clk);
        chk({pfx, "_pce_clk2"}, 32'(pce0), 1);
        chk({pfx, "_x_hold"}, 32'(x0), 799);
        @(negedge clk);
        chk({pfx, "_x0"}, 32'(x0), 0);
        chk({pfx, "_y0"}, 32'(y0), 0);
        chk({pfx, "_de1"}, 32'(de0), 1);
        chk({pfx, "_ls1"}, 32'(ls0), 1);
        chk({pfx, "_fs1"}, 32'(fs0), 1);
        @(negedge clk);
        chk({pfx, "_ls_1clk"}, 32'(ls0), 0);
        chk({pfx, "_fs_1clk"}, 32'(fs0), 0);
    endtask

    int          de_cnt, hl_cnt, hl_first, ls_cnt, fs_cnt, ls_second;
    int          vl_cnt, vl_first, vl_y, cnt, ok, xa, ya, xb, yb, fsb;
    logic [24:0] snap;

    initial begin
        rst0 = 1'b1; en0 = 1'b1; rst1 = 1'b1; en1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_rst0("rst");

        // reset release, first pixel, then one full line measured from line_start
        rst0 = 1'b0;
        chk_start0("start");
        de_cnt = 1; hl_cnt = 0; hl_first = -1; ls_cnt = 1;
        for (int k = 1; k < 1600; k++) begin
            if (de0) de_cnt++;
            if (!hs0) begin
                if (hl_first < 0) hl_first = k;
                hl_cnt++;
            end
            if (ls0) ls_cnt++;
            @(negedge clk);
        end
        chk("line_de_clks", 32'(de_cnt), 1280);
        chk("line_hs_low", 32'(hl_cnt), 192);
        chk("line_hs_start", 32'(hl_first), 1312);
        chk("line_ls_count", 32'(ls_cnt), 1);
        chk("line_period_ls", 32'(ls0), 1);
        chk("line_wrap_x", 32'(x0), 0);
        chk("line_wrap_y", 32'(y0), 1);
        chk("line_no_fs", 32'(fs0), 0);

        // enable freeze at x=300 for 50 clocks
        cnt = 0;
        while (x0 != 10'd300 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("frz_to_x300", 32'(cnt), 600);
        en0  = 1'b0;
        snap = {x0, y0, hs0, vs0, de0, ls0, fs0};
        ok   = 1;
        repeat (50) begin
            @(negedge clk);
            cnt++;
            if ({x0, y0, hs0, vs0, de0, ls0, fs0} !== snap || pce0 !== 1'b0) ok = 0;
        end
        chk("frz_hold", 32'(ok), 1);
        en0 = 1'b1;
        @(negedge clk); cnt++;
        chk("frz_resume_pce", 32'(pce0), 1);
        chk("frz_resume_x", 32'(x0), 300);
        @(negedge clk); cnt++;
        chk("frz_x301", 32'(x0), 301);
        repeat (2) @(negedge clk);
        cnt += 2;
        chk("frz_x302", 32'(x0), 302);
        while (!ls0 && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        chk("frz_line_len", 32'(cnt), 1650);

        // asynchronous reset mid-line, taken while pix_ce is high
        cnt = 0;
        while (x0 != 10'd500 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid_reach_x500", 32'(x0), 500);
        @(negedge clk);
        chk("mid_pce_pre", 32'(pce0), 1);
        rst0 = 1'b1;
        #1;
        chk_rst0("mid_async");
        repeat (3) @(negedge clk);
        chk_rst0("mid_held");
        rst0 = 1'b0;
        chk_start0("mid_restart");

        // CE_DIV=1 build: pix_ce follows en, short frames
        chk("d1_pce_en0", 32'(pce1), 0);
        en1 = 1'b1;
        #1;
        chk("d1_pce_en1", 32'(pce1), 1);
        chk("d1_rst_x", 32'(x1), 799);
        chk("d1_rst_vs", 32'(vs1), 1);
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk("d1_start_x", 32'(x1), 0);
        chk("d1_start_y", 32'(y1), 0);
        chk("d1_start_fs", 32'(fs1), 1);
        chk("d1_start_de", 32'(de1), 1);
        ls_cnt = 0; fs_cnt = 0; ls_second = -1; hl_cnt = 0;
        vl_cnt = 0; vl_first = -1; vl_y = -1;
        xa = -1; ya = -1; xb = -1; yb = -1; fsb = -1;
        for (int k = 0; k < 12800; k++) begin
            if (ls1) begin
                ls_cnt++;
                if (k > 0 && ls_second < 0) ls_second = k;
            end
            if (fs1) fs_cnt++;
            if (k < 800 && !hs1) hl_cnt++;
            if (k < 6400 && !vs1) begin
                if (vl_first < 0) begin
                    vl_first = k;
                    vl_y     = int'(y1);
                end
                vl_cnt++;
            end
            if (k == 6399) begin xa = int'(x1); ya = int'(y1); end
            if (k == 6400) begin xb = int'(x1); yb = int'(y1); fsb = int'(fs1); end
            @(negedge clk);
        end
        chk("d1_line_period", 32'(ls_second), 800);
        chk("d1_ls_count", 32'(ls_cnt), 16);
        chk("d1_hs_low", 32'(hl_cnt), 96);
        chk("d1_vs_low", 32'(vl_cnt), 1600);
        chk("d1_vs_start", 32'(vl_first), 4000);
        chk("d1_vs_start_y", 32'(vl_y), 5);
        chk("d1_prewrap_x", 32'(xa), 799);
        chk("d1_prewrap_y", 32'(ya), 7);
        chk("d1_wrap_x", 32'(xb), 0);
        chk("d1_wrap_y", 32'(yb), 0);
        chk("d1_wrap_fs", 32'(fsb), 1);
        chk("d1_fs_count", 32'(fs_cnt), 2);
        chk("d1_frame2_fs", 32'(fs1), 1);
        en1 = 1'b0;
        #1;
        chk("d1_pce_drop", 32'(pce1), 0);
        @(negedge clk);
        chk("d1_freeze_x", 32'(x1), 0);
        chk("d1_fs_no_repeat", 32'(fs1), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencing controller for the VGA output path: generates the pixel clock-enable from the 50 MHz system clock and drives the horizontal/vertical counters, sync pulses, data-enable and pixel coordinates for 640x480@60 Hz. It replaces a free-running divided clock with a single-clock-domain enable, so the pixel fetch and colour logic run on `clk` and are qualified by `pix_ce`. It sits between the system clock/reset and the frame-buffer read and colour-output logic.

## Interface
- `CE_DIV`, 2: system clocks per pixel; legal 1..16.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, pixels.
- `H_SYNC`, 96: hsync width, pixels.
- `H_BP`, 48: horizontal back porch, pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, lines.
- `V_SYNC`, 2: vsync width, lines.
- `V_BP`, 33: vertical back porch, lines.
- `SYNC_POL`, 0: asserted sync level (0 = active-low).

- `clk` in 1: system clock, 50 MHz. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable; low freezes all timing.
- `pix_ce` out 1: pixel clock-enable, one `clk` wide.
- `hsync` out 1: horizontal sync.
- `vsync` out 1: vertical sync.
- `de` out 1: high in the active region.
- `x` out 10: current horizontal count.
- `y` out 10: current vertical count.
- `line_start` out 1: one-`clk` pulse when `x` wraps to 0.
- `frame_start` out 1: one-`clk` pulse when (`x`,`y`) becomes (0,0).

## Operation
- H_TOTAL = sum of H params (800). V_TOTAL = sum of V params (525). Both must be ≤ 1024.
- Prescaler `ce_cnt` counts 0..CE_DIV-1 while `en`=1. `pix_ce` = (`ce_cnt`==CE_DIV-1) && `en`, combinational from `ce_cnt`. With CE_DIV=1, `pix_ce` = `en`.
- Each `pix_ce` cycle advances the counters at the closing edge:
  - `x` increments, wrapping H_TOTAL-1 to 0.
  - `y` increments only on the `x` wrap, wrapping V_TOTAL-1 to 0.
  - Simultaneous wrap at (799,524) goes to (0,0).
- Horizontal regions: active 0..639, FP 640..655, sync 656..751, BP 752..799. Vertical regions: active 0..479, FP 480..489, sync 490..491, BP 492..524.
- `hsync` = SYNC_POL while `x` is in the sync region, else ~SYNC_POL. `vsync` follows the same rule on `y`.
- `de` = (`x` < H_ACTIVE) && (`y` < V_ACTIVE).
- `x` and `y` are the raw counters. Consumers qualify them with `de`.
- All outputs except `pix_ce` are registered and update on the same edge as the counters, so they are always mutually consistent, with no skew between sync and counters.
- `line_start` is high for the single `clk` following the edge where `x` became 0. `frame_start` is high for the single `clk` following the edge where `x` and `y` both became 0. Both pulses are one `clk` long, not one pixel long.
- `en`=0 behaviour:
  - `ce_cnt`, counters and registered outputs hold.
  - `pix_ce`=0.
  - Pulses deassert after one cycle and do not repeat.
  - Re-asserting `en` resumes from the held state.
- States: the block has no FSM beyond the counters. The region decode acts as the state: ACTIVE, FP, SYNC, BP per axis.

## Timing
- Reset values:
  - `ce_cnt`=0, `x`=H_TOTAL-1 (799), `y`=V_TOTAL-1 (524).
  - `hsync`=`vsync`=~SYNC_POL (1), `de`=0, `pix_ce`=0.
  - `line_start`=`frame_start`=0.
- Reset is asynchronous and may assert mid-frame. All state returns to the reset values immediately; no partial line completes.
- Assuming `en` is held high after `rst` falls, the first `pix_ce` occurs at clock CE_DIV (clock 2 with default params). Its closing edge sets (`x`,`y`)=(0,0), `de`=1, `line_start`=1 and `frame_start`=1.
- One line = H_TOTAL×CE_DIV clocks (1600). One frame = 840000 clocks.
- Latency from `pix_ce` to the output change is 0 cycles: the outputs change at the edge that closes the `pix_ce` cycle.

## Test plan
- Reset check: assert `rst`, hold `en`=1, release. Outputs read 799/524, `hsync`=`vsync`=1, `de`=0. On the second clock `pix_ce`=1. On the next edge (`x`,`y`)=(0,0) with `de`=1 and `frame_start`/`line_start` high for exactly 1 clock.
- Line timing: run one line. Expect:
  - `de` high for 1280 clocks.
  - `hsync` low for exactly 192 clocks, starting 1312 clocks after `line_start`.
  - `line_start` period of 1600 clocks.
- Frame timing: run two frames. Expect:
  - `vsync` low for 3200 clocks, starting when `y`=490.
  - `frame_start` period of 840000 clocks.
  - The wrap at (799,524) goes to (0,0) in one step.
- Enable freeze: drop `en` at `x`=300 for 50 clocks. Expect all outputs constant and `pix_ce`=0 for the whole window. After re-assertion, `x` continues 301, 302, … and the line length grows by exactly 50 clocks.
- Mid-frame reset: assert `rst` at `y`=200, `x`=500 for 3 clocks. Outputs return to the reset values asynchronously, then the sequence restarts exactly as in the reset-check scenario.
- CE_DIV=1 build: `pix_ce` equals `en`. The line period is 800 clocks and the hsync low width is 96 clocks.
